// File: rtl/rgmii_rx_inband_status.sv
// RGMII in-band status decoder: qualifies link/speed/duplex seen during IFG and publishes it.
// Optional saturating statistics counters when RX_INBAND_STATS_EN is defined.
module rgmii_rx_inband_status #(
   parameter int unsigned AGREE_COUNT  = 8,
   parameter int unsigned STALE_CYCLES = 125000,
   parameter int unsigned STALE_BITS   = $clog2(STALE_CYCLES + 1)
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        rx_dv,
   input  logic        rx_er,
   input  logic [3:0]  rxd,
   output logic        rx_speed_10,
   output logic        rx_speed_100,
   output logic        rx_speed_1000,
   output logic        rx_link_up,
   output logic        rx_full_duplex,
   output logic        status_valid,
   output logic        status_change
`ifdef RX_INBAND_STATS_EN
   ,
   output logic [15:0] commit_count,
   output logic [15:0] reserved_count,
   output logic [15:0] false_carrier_count
`endif
);

   localparam int unsigned CNT_W = $clog2(AGREE_COUNT + 1);
   localparam int unsigned WD_W  = (STALE_BITS > 0) ? STALE_BITS : 1;
   localparam logic [CNT_W-1:0] AGREE_LAST = CNT_W'(AGREE_COUNT - 1);
   localparam logic [CNT_W-1:0] AGREE_FULL = CNT_W'(AGREE_COUNT);
   localparam logic [WD_W-1:0]  WD_LIMIT   = WD_W'(STALE_CYCLES);

   typedef enum logic [1:0] {S_ACQUIRE, S_QUALIFY, S_LOCKED} state_t;

   logic             r_dv, r_er;
   logic [3:0]       r_rxd;
   state_t           r_state, w_state_nx;
   logic [4:0]       r_cand, w_cand_nx;
   logic [CNT_W-1:0] r_cnt, w_cnt_nx;
   logic [WD_W-1:0]  r_wd, w_wd_nx;
   logic [2:0]       r_spd, w_spd_nx;
   logic             r_link, w_link_nx;
   logic             r_dup, w_dup_nx;
   logic             r_valid, w_valid_nx;
   logic             r_chg, w_chg_nx;

   logic             w_stat, w_fc, w_rej, w_good;
   logic [2:0]       w_spd;
   logic [4:0]       w_smp, w_cmt;

   // Tuples are {duplex, link, one-hot speed}; reserved link-down keeps committed speed.
   always_comb begin
      w_stat = !r_dv && !r_er;
      w_fc   = !r_dv && r_er;
      w_rej  = w_stat && (r_rxd[2:1] == 2'b11) && r_rxd[0];
      w_good = w_stat && !w_rej;
      unique case (r_rxd[2:1])
         2'b00:   w_spd = 3'b001;
         2'b01:   w_spd = 3'b010;
         2'b10:   w_spd = 3'b100;
         default: w_spd = r_spd;
      endcase
      w_smp = {r_rxd[3], r_rxd[0], w_spd};
      w_cmt = {r_dup, r_link, r_spd};
   end

   always_comb begin
      w_state_nx = r_state;
      w_cand_nx  = r_cand;
      w_cnt_nx   = r_cnt;
      w_wd_nx    = r_wd;
      w_spd_nx   = r_spd;
      w_link_nx  = r_link;
      w_dup_nx   = r_dup;
      w_valid_nx = r_valid;
      w_chg_nx   = 1'b0;
      if (w_good) begin
         w_wd_nx = '0;
         unique case (r_state)
            S_ACQUIRE: begin
               w_cand_nx  = w_smp;
               w_cnt_nx   = CNT_W'(1);
               w_state_nx = S_QUALIFY;
            end
            S_QUALIFY: begin
               if (w_smp == r_cand) begin
                  if (r_cnt >= AGREE_LAST) begin
                     w_cnt_nx   = AGREE_FULL;
                     w_state_nx = S_LOCKED;
                     w_spd_nx   = w_smp[2:0];
                     w_link_nx  = w_smp[3];
                     w_dup_nx   = w_smp[4];
                     w_valid_nx = 1'b1;
                     w_chg_nx   = (w_smp != w_cmt) || !r_valid;
                  end else begin
                     w_cnt_nx = r_cnt + 1'b1;
                  end
               end else begin
                  w_cand_nx = w_smp;
                  w_cnt_nx  = CNT_W'(1);
               end
            end
            S_LOCKED: begin
               if (w_smp != w_cmt) begin
                  w_cand_nx  = w_smp;
                  w_cnt_nx   = CNT_W'(1);
                  w_state_nx = S_QUALIFY;
               end
            end
            default: w_state_nx = S_ACQUIRE;
         endcase
      end else begin
         if (w_fc || w_rej) begin
            w_cnt_nx   = '0;
            w_state_nx = S_ACQUIRE;
         end
         if ((STALE_CYCLES != 0) && (r_wd != WD_LIMIT)) begin
            w_wd_nx = r_wd + 1'b1;
            if (w_wd_nx == WD_LIMIT) begin
               w_link_nx  = 1'b0;
               w_valid_nx = 1'b0;
               w_cnt_nx   = '0;
               w_state_nx = S_ACQUIRE;
               w_chg_nx   = r_link;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_dv    <= 1'b0;
         r_er    <= 1'b0;
         r_rxd   <= '0;
         r_state <= S_ACQUIRE;
         r_cand  <= '0;
         r_cnt   <= '0;
         r_wd    <= '0;
         r_spd   <= '0;
         r_link  <= 1'b0;
         r_dup   <= 1'b0;
         r_valid <= 1'b0;
         r_chg   <= 1'b0;
      end else begin
         r_dv    <= rx_dv;
         r_er    <= rx_er;
         r_rxd   <= rxd;
         r_state <= w_state_nx;
         r_cand  <= w_cand_nx;
         r_cnt   <= w_cnt_nx;
         r_wd    <= w_wd_nx;
         r_spd   <= w_spd_nx;
         r_link  <= w_link_nx;
         r_dup   <= w_dup_nx;
         r_valid <= w_valid_nx;
         r_chg   <= w_chg_nx;
      end
   end

   assign rx_speed_10    = r_spd[0];
   assign rx_speed_100   = r_spd[1];
   assign rx_speed_1000  = r_spd[2];
   assign rx_link_up     = r_link;
   assign rx_full_duplex = r_dup;
   assign status_valid   = r_valid;
   assign status_change  = r_chg;

`ifdef RX_INBAND_STATS_EN
   logic [15:0] r_commit_cnt, r_rsv_cnt, r_fc_cnt;
   logic        w_commit;

   // Only a commit can move the FSM into S_LOCKED from another state.
   assign w_commit = (w_state_nx == S_LOCKED) && (r_state != S_LOCKED);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_commit_cnt <= '0;
         r_rsv_cnt    <= '0;
         r_fc_cnt     <= '0;
      end else begin
         if (w_commit && (r_commit_cnt != '1)) r_commit_cnt <= r_commit_cnt + 1'b1;
         if (w_rej && (r_rsv_cnt != '1))       r_rsv_cnt    <= r_rsv_cnt + 1'b1;
         if (w_fc && (r_fc_cnt != '1))         r_fc_cnt     <= r_fc_cnt + 1'b1;
      end
   end

   assign commit_count        = r_commit_cnt;
   assign reserved_count      = r_rsv_cnt;
   assign false_carrier_count = r_fc_cnt;
`endif

endmodule

// File: tb/tb_rgmii_rx_inband_status.sv
// Directed plus randomized bench for rgmii_rx_inband_status against a sample-level reference model.
// Stats checks are active when RX_INBAND_STATS_EN is defined.
module tb_rgmii_rx_inband_status;

   localparam int AGREE = 8;
   localparam int STALE = 16;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       rx_dv = 1'b0, rx_er = 1'b0;
   logic [3:0] rxd = 4'h0;
   logic       rx_speed_10, rx_speed_100, rx_speed_1000;
   logic       rx_link_up, rx_full_duplex, status_valid, status_change;
`ifdef RX_INBAND_STATS_EN
   logic [15:0] commit_count, reserved_count, false_carrier_count;
`endif

   rgmii_rx_inband_status #(.AGREE_COUNT(AGREE), .STALE_CYCLES(STALE)) dut (
      .clk(clk), .reset_n(reset_n), .rx_dv(rx_dv), .rx_er(rx_er), .rxd(rxd),
      .rx_speed_10(rx_speed_10), .rx_speed_100(rx_speed_100), .rx_speed_1000(rx_speed_1000),
      .rx_link_up(rx_link_up), .rx_full_duplex(rx_full_duplex),
      .status_valid(status_valid), .status_change(status_change)
`ifdef RX_INBAND_STATS_EN
      , .commit_count(commit_count), .reserved_count(reserved_count),
      .false_carrier_count(false_carrier_count)
`endif
   );

   always #5 clk = ~clk;

   int n_chk = 0, n_pass = 0, n_fail = 0;

   // Reference model: speeds held as Mb/s integers, qualification as a run length.
   logic       p_dv, p_er;
   logic [3:0] p_rxd;
   int  m_run, m_idle, cl, cs, cd, c_link, c_speed, c_dup, c_valid;
   int  m_ncommit, m_nrsv, m_nfc;
   bit  m_locked, m_chg;

   task automatic model_reset();
      p_dv = 0; p_er = 0; p_rxd = 4'h0;
      m_run = 0; m_idle = 0; cl = 0; cs = 0; cd = 0;
      c_link = 0; c_speed = 0; c_dup = 0; c_valid = 0;
      m_ncommit = 0; m_nrsv = 0; m_nfc = 0; m_locked = 0; m_chg = 0;
   endtask

   task automatic model_step();
      int link, dup, code, sp;
      bit good;
      m_chg = 0; good = 0;
      if (!p_dv && !p_er) begin
         link = int'(p_rxd[0]); dup = int'(p_rxd[3]); code = int'(p_rxd[2:1]);
         if (code == 3 && link == 1) begin
            m_run = 0; m_locked = 0;
            if (m_nrsv < 65535) m_nrsv++;
         end else begin
            good = 1; m_idle = 0;
            sp = (code == 0) ? 10 : (code == 1) ? 100 : (code == 2) ? 1000 : c_speed;
            if (m_locked) begin
               if (link != c_link || sp != c_speed || dup != c_dup) begin
                  m_locked = 0; cl = link; cs = sp; cd = dup; m_run = 1;
               end
            end else if (m_run > 0 && link == cl && sp == cs && dup == cd) begin
               m_run++;
               if (m_run == AGREE) begin
                  m_chg = (link != c_link || sp != c_speed || dup != c_dup || c_valid == 0);
                  c_link = link; c_speed = sp; c_dup = dup; c_valid = 1;
                  m_locked = 1;
                  if (m_ncommit < 65535) m_ncommit++;
               end
            end else begin
               cl = link; cs = sp; cd = dup; m_run = 1;
            end
         end
      end else if (!p_dv) begin
         m_run = 0; m_locked = 0;
         if (m_nfc < 65535) m_nfc++;
      end
      if (!good && m_idle < STALE) begin
         m_idle++;
         if (m_idle == STALE) begin
            m_chg = (c_link == 1);
            c_link = 0; c_valid = 0; m_run = 0; m_locked = 0;
         end
      end
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_model();
      chk("spd10",  16'(rx_speed_10),    16'(c_speed == 10));
      chk("spd100", 16'(rx_speed_100),   16'(c_speed == 100));
      chk("spd1000",16'(rx_speed_1000),  16'(c_speed == 1000));
      chk("link",   16'(rx_link_up),     16'(c_link));
      chk("duplex", 16'(rx_full_duplex), 16'(c_dup));
      chk("valid",  16'(status_valid),   16'(c_valid));
      chk("change", 16'(status_change),  16'(m_chg));
`ifdef RX_INBAND_STATS_EN
      chk("n_commit", commit_count,        16'(m_ncommit));
      chk("n_rsv",    reserved_count,      16'(m_nrsv));
      chk("n_fc",     false_carrier_count, 16'(m_nfc));
`endif
   endtask

   // One clock: drive inputs, let the edge happen, advance the model, compare.
   task automatic cyc(input logic dv, input logic er, input logic [3:0] d);
      rx_dv = dv; rx_er = er; rxd = d;
      @(posedge clk);
      #1;
      model_step();
      p_dv = dv; p_er = er; p_rxd = d;
      check_model();
   endtask

   task automatic rep(input int n, input logic dv, input logic er, input logic [3:0] d);
      for (int i = 0; i < n; i++) cyc(dv, er, d);
   endtask

   logic [3:0] pats [7];

   initial begin
      pats[0] = 4'b0101; pats[1] = 4'b1011; pats[2] = 4'b0011; pats[3] = 4'b0000;
      pats[4] = 4'b1100; pats[5] = 4'b0111; pats[6] = 4'b0110;
      model_reset();
      @(posedge clk); @(posedge clk); #1;
      chk("reset_spd",   16'({rx_speed_10, rx_speed_100, rx_speed_1000}), 16'h0);
      chk("reset_link",  16'(rx_link_up), 16'h0);
      chk("reset_valid", 16'(status_valid), 16'h0);
      chk("reset_chg",   16'(status_change), 16'h0);
      reset_n = 1'b1;

      // Acquire link-up 1000 half
      rep(8, 0, 0, 4'b0101);
      chk("t1_pre_valid", 16'(status_valid), 16'h0);
      cyc(0, 0, 4'b0101);
      chk("t1_link", 16'(rx_link_up), 16'h1);
      chk("t1_1000", 16'(rx_speed_1000), 16'h1);
      chk("t1_chg",  16'(status_change), 16'h1);
      cyc(0, 0, 4'b0101);
      chk("t1_chg_once", 16'(status_change), 16'h0);

      // Interrupted run, then a full run to 100 full
      rep(7, 0, 0, 4'b1011);
      cyc(0, 0, 4'b0101);
      chk("t2_hold", 16'(rx_speed_1000), 16'h1);
      rep(8, 0, 0, 4'b1011);
      chk("t2_pre", 16'(rx_speed_100), 16'h0);
      cyc(1, 0, 4'h0);
      chk("t2_100", 16'(rx_speed_100), 16'h1);
      chk("t2_fd",  16'(rx_full_duplex), 16'h1);

      // Frame data mid-qualification holds the count
      rep(4, 0, 0, 4'b0011);
      for (int i = 0; i < 14; i++) cyc(1, 0, 4'($urandom));
      rep(3, 0, 0, 4'b0011);
      cyc(0, 0, 4'b0011);
      chk("t3_pre", 16'(rx_full_duplex), 16'h1);
      cyc(1, 0, 4'h0);
      chk("t3_hd",  16'(rx_full_duplex), 16'h0);
      chk("t3_chg", 16'(status_change), 16'h1);

      // False carrier restarts qualification
      rep(6, 0, 0, 4'b0101);
      cyc(0, 1, 4'h0);
      rep(7, 0, 0, 4'b0101);
      cyc(1, 0, 4'h0);
      chk("t4_pre", 16'(rx_speed_1000), 16'h0);
      cyc(0, 0, 4'b0101);
      cyc(1, 0, 4'h0);
      chk("t4_1000", 16'(rx_speed_1000), 16'h1);

      // Watchdog
      rep(15, 1, 0, 4'hA);
      chk("t5_pre", 16'(rx_link_up), 16'h1);
      cyc(1, 0, 4'hA);
      chk("t5_link",  16'(rx_link_up), 16'h0);
      chk("t5_valid", 16'(status_valid), 16'h0);
      chk("t5_chg",   16'(status_change), 16'h1);
      chk("t5_spd",   16'(rx_speed_1000), 16'h1);

      // Reserved speed code with link
      rep(8, 0, 0, 4'b0111);
      cyc(1, 0, 4'h0);
      chk("t6_valid", 16'(status_valid), 16'h0);
`ifdef RX_INBAND_STATS_EN
      chk("t6_rsv", reserved_count, 16'd8);
`endif

      // Randomized bursts
      for (int b = 0; b < 60; b++) begin
         int r;
         r = int'($urandom_range(0, 9));
         if (r == 0) begin
            for (int i = 0; i < int'($urandom_range(1, 20)); i++) cyc(1, 1'($urandom), 4'($urandom));
         end else if (r == 1) begin
            cyc(0, 1, 4'($urandom));
         end else begin
            rep(int'($urandom_range(1, 12)), 0, 0, pats[$urandom_range(0, 6)]);
         end
      end

      // Async reset while locked
      rep(10, 0, 0, 4'b1101);
      #2 reset_n = 1'b0;
      #1;
      model_reset();
      chk("rst_link",  16'(rx_link_up), 16'h0);
      chk("rst_spd",   16'({rx_speed_10, rx_speed_100, rx_speed_1000}), 16'h0);
      chk("rst_valid", 16'(status_valid), 16'h0);
      @(posedge clk); #1;
      reset_n = 1'b1;
      rep(10, 0, 0, 4'b1011);
      chk("rst_relock", 16'(rx_speed_100), 16'h1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

endmodule
